// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle produced by vga_timing_gen: position counters, display
// qualifier, sync pins and the pixel/frame strobes.
interface vga_timing_gen_if;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic       inDisplayArea;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       PixelTick;
  logic       FrameTick;

  modport master (
    output CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
           PixelTick, FrameTick
  );

  modport slave (
    input  CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
           PixelTick, FrameTick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel divider, X/Y counters and
// registered sync/qualifier/strobe outputs aligned with the counters.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  localparam logic [9:0] X_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] X_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  logic       r_run;
  logic [2:0] r_div;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_in;
  logic       r_hs;
  logic       r_vs;
  logic       r_pt;
  logic       r_ft;

  logic       w_step;
  logic [2:0] w_div_nxt;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;

  // r_run holds the divider at 0 for the first cycle after reset so that
  // position (0,0) is presented with the qualifier already valid.
  assign w_step = r_run && (r_div == DIV_LAST);

  always_comb begin
    w_div_nxt = r_div;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_run) begin
      w_div_nxt = (r_div == DIV_LAST) ? 3'd0 : r_div + 3'd1;
    end
    if (w_step) begin
      if (r_x == X_LAST) begin
        w_x_nxt = 10'd0;
        w_y_nxt = (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
      end else begin
        w_x_nxt = r_x + 10'd1;
      end
    end
  end

  // Derived outputs come from the next position so they switch with the counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run <= 1'b0;
      r_div <= 3'd0;
      r_x   <= 10'd0;
      r_y   <= 10'd0;
      r_in  <= 1'b0;
      r_hs  <= ~SYNC_ACTIVE;
      r_vs  <= ~SYNC_ACTIVE;
      r_pt  <= 1'b0;
      r_ft  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_div <= w_div_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_in  <= (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
      r_hs  <= ((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vs  <= ((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_pt  <= (w_div_nxt == DIV_LAST);
      r_ft  <= w_step && (w_x_nxt == 10'd0) && (w_y_nxt == Y_ACT);
    end
  end

  assign vga.CounterX      = r_x;
  assign vga.CounterY      = r_y;
  assign vga.inDisplayArea = r_in;
  assign vga.vga_h_sync    = r_hs;
  assign vga.vga_v_sync    = r_vs;
  assign vga.PixelTick     = r_pt;
  assign vga.FrameTick     = r_ft;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four instances (reduced raster at
// CLK_DIV 2/1/4 plus the default 640x480 timing) checked against hand vectors.
module tb_vga_timing_gen;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();
  vga_timing_gen_if if3 ();

  // Reduced raster: H 8+2+3+3=16 (hsync X 10..12), V 6+2+2+2=12 (vsync Y 8..9).
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE(1'b0))
    u_main (.Clk(Clk), .Reset(Reset), .vga(if0));
  vga_timing_gen u_dflt (.Clk(Clk), .Reset(Reset), .vga(if1));
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE(1'b0))
    u_div1 (.Clk(Clk), .Reset(Reset), .vga(if2));
  vga_timing_gen #(.CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE(1'b0))
    u_div4 (.Clk(Clk), .Reset(Reset), .vga(if3));

  typedef struct {
    int          dut;
    int          ep;
    int          cyc;
    logic [24:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   ft_cyc[$];
  int   cyc = -100;
  int   epoch = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   done = 1'b0;
  bit   final_done = 1'b0;

  // Cycle 0 is the first cycle after the first edge that samples Reset low.
  always @(posedge Clk) begin
    if (Reset) begin
      if (cyc != -1) epoch <= epoch + 1;
      cyc <= -1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  task automatic ex(input int d, input int e, input int c, input int x, input int y,
                    input logic in, input logic hs, input logic vs,
                    input logic pt, input logic ft);
    exp_t t;
    t.dut = d;
    t.ep  = e;
    t.cyc = c;
    t.v   = {10'(x), 10'(y), in, hs, vs, pt, ft};
    sb_q.push_back(t);
  endtask

  function automatic logic [24:0] obs(input int d);
    case (d)
      0: return {if0.CounterX, if0.CounterY, if0.inDisplayArea, if0.vga_h_sync,
                 if0.vga_v_sync, if0.PixelTick, if0.FrameTick};
      1: return {if1.CounterX, if1.CounterY, if1.inDisplayArea, if1.vga_h_sync,
                 if1.vga_v_sync, if1.PixelTick, if1.FrameTick};
      2: return {if2.CounterX, if2.CounterY, if2.inDisplayArea, if2.vga_h_sync,
                 if2.vga_v_sync, if2.PixelTick, if2.FrameTick};
      default: return {if3.CounterX, if3.CounterY, if3.inDisplayArea, if3.vga_h_sync,
                       if3.vga_v_sync, if3.PixelTick, if3.FrameTick};
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares mid-cycle.
  always @(negedge Clk) begin
    logic [24:0] got;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].ep == epoch && sb_q[i].cyc == cyc) begin
        got = obs(sb_q[i].dut);
        n_vec++;
        if (got !== sb_q[i].v) begin
          n_err++;
          $display("FAIL dut%0d e%0d c%0d: got x=%0d y=%0d in,hs,vs,pt,ft=%b required x=%0d y=%0d in,hs,vs,pt,ft=%b",
                   sb_q[i].dut, sb_q[i].ep, sb_q[i].cyc, got[24:15], got[14:5], got[4:0],
                   sb_q[i].v[24:15], sb_q[i].v[14:5], sb_q[i].v[4:0]);
        end
        sb_q.delete(i);
      end
    end
    if (epoch == 1 && cyc >= 0 && cyc < 1152 && if0.FrameTick === 1'b1)
      ft_cyc.push_back(cyc);
    if (done && !final_done) begin
      foreach (sb_q[i]) begin
        n_vec++;
        n_err++;
        $display("FAIL missed dut%0d e%0d c%0d: got never-sampled required %b",
                 sb_q[i].dut, sb_q[i].ep, sb_q[i].cyc, sb_q[i].v);
      end
      n_vec++;
      if (ft_cyc.size() != 3) begin
        n_err++;
        $display("FAIL frametick_count: got %0d required 3", ft_cyc.size());
      end else begin
        n_vec++;
        if (ft_cyc[0] != 192 || ft_cyc[1] - ft_cyc[0] != 384 || ft_cyc[2] - ft_cyc[1] != 384) begin
          n_err++;
          $display("FAIL frametick_spacing: got %0d,%0d,%0d required 192,576,960",
                   ft_cyc[0], ft_cyc[1], ft_cyc[2]);
        end
      end
      final_done = 1'b1;
    end
  end

  initial begin
    // Reset state, all instances.
    for (int d = 0; d < 4; d++) ex(d, 1, -1, 0, 0, 0, 1, 1, 0, 0);
    // Reduced raster, CLK_DIV=2: position (x,y) starts at cycle 2*(16y+x).
    ex(0, 1, 0,    0,  0, 1, 1, 1, 0, 0);
    ex(0, 1, 1,    0,  0, 1, 1, 1, 1, 0);
    ex(0, 1, 2,    1,  0, 1, 1, 1, 0, 0);
    ex(0, 1, 15,   7,  0, 1, 1, 1, 1, 0);
    ex(0, 1, 16,   8,  0, 0, 1, 1, 0, 0);
    ex(0, 1, 19,   9,  0, 0, 1, 1, 1, 0);
    ex(0, 1, 20,  10,  0, 0, 0, 1, 0, 0);
    ex(0, 1, 25,  12,  0, 0, 0, 1, 1, 0);
    ex(0, 1, 26,  13,  0, 0, 1, 1, 0, 0);
    ex(0, 1, 31,  15,  0, 0, 1, 1, 1, 0);
    ex(0, 1, 32,   0,  1, 1, 1, 1, 0, 0);
    ex(0, 1, 107,  5,  3, 1, 1, 1, 1, 0);
    ex(0, 1, 191, 15,  5, 0, 1, 1, 1, 0);
    ex(0, 1, 192,  0,  6, 0, 1, 1, 0, 1);
    ex(0, 1, 193,  0,  6, 0, 1, 1, 1, 0);
    ex(0, 1, 255, 15,  7, 0, 1, 1, 1, 0);
    ex(0, 1, 256,  0,  8, 0, 1, 0, 0, 0);
    ex(0, 1, 319, 15,  9, 0, 1, 0, 1, 0);
    ex(0, 1, 320,  0, 10, 0, 1, 1, 0, 0);
    ex(0, 1, 383, 15, 11, 0, 1, 1, 1, 0);
    ex(0, 1, 384,  0,  0, 1, 1, 1, 0, 0);
    ex(0, 1, 576,  0,  6, 0, 1, 1, 0, 1);
    ex(0, 1, 960,  0,  6, 0, 1, 1, 0, 1);
    ex(0, 1, 3563, 5,  3, 1, 1, 1, 1, 0);
    // After the mid-frame reset the release sequence repeats.
    ex(0, 2, -1,   0,  0, 0, 1, 1, 0, 0);
    ex(0, 2, 0,    0,  0, 1, 1, 1, 0, 0);
    ex(0, 2, 1,    0,  0, 1, 1, 1, 1, 0);
    ex(0, 2, 2,    1,  0, 1, 1, 1, 0, 0);
    // Default 640x480 timing, horizontal boundaries.
    ex(1, 1, 1278, 639, 0, 1, 1, 1, 0, 0);
    ex(1, 1, 1280, 640, 0, 0, 1, 1, 0, 0);
    ex(1, 1, 1311, 655, 0, 0, 1, 1, 1, 0);
    ex(1, 1, 1312, 656, 0, 0, 0, 1, 0, 0);
    ex(1, 1, 1503, 751, 0, 0, 0, 1, 1, 0);
    ex(1, 1, 1504, 752, 0, 0, 1, 1, 0, 0);
    ex(1, 1, 1599, 799, 0, 0, 1, 1, 1, 0);
    ex(1, 1, 1600,   0, 1, 1, 1, 1, 0, 0);
    ex(1, 1, 3200,   0, 2, 1, 1, 1, 0, 0);
    // CLK_DIV=1: advance every cycle, frame = 192 cycles.
    ex(2, 1, 0,    0, 0, 1, 1, 1, 1, 0);
    ex(2, 1, 1,    1, 0, 1, 1, 1, 1, 0);
    ex(2, 1, 10,  10, 0, 0, 0, 1, 1, 0);
    ex(2, 1, 96,   0, 6, 0, 1, 1, 1, 1);
    ex(2, 1, 97,   1, 6, 0, 1, 1, 1, 0);
    ex(2, 1, 192,  0, 0, 1, 1, 1, 1, 0);
    ex(2, 1, 288,  0, 6, 0, 1, 1, 1, 1);
    // CLK_DIV=4: each position held 4 cycles, tick on the 4th.
    ex(3, 1, 0,    0, 0, 1, 1, 1, 0, 0);
    ex(3, 1, 2,    0, 0, 1, 1, 1, 0, 0);
    ex(3, 1, 3,    0, 0, 1, 1, 1, 1, 0);
    ex(3, 1, 4,    1, 0, 1, 1, 1, 0, 0);
    ex(3, 1, 7,    1, 0, 1, 1, 1, 1, 0);
    ex(3, 1, 40,  10, 0, 0, 0, 1, 0, 0);
    ex(3, 1, 384,  0, 6, 0, 1, 1, 0, 1);

    Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int k = 0; k < 5000 && !(epoch == 1 && cyc == 3563); k++) begin
      @(posedge Clk);
      #1;
    end
    // Reset sampled at the edge ending cycle 3563 (main at (5,3), divider 1).
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (12) @(posedge Clk);
    done = 1'b1;
    for (int k = 0; k < 10 && !final_done; k++) @(posedge Clk);
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
